// File: rtl/fb_pkg.sv
// Shared types and helpers for the triple-buffer ownership controller.
package fb_pkg;

  localparam int NUM_BUF = 3;
  localparam int FB_ADDR_W = 32;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } fb_state_t;

  // Constant three-way mux: only indices 0..2 are ever presented.
  function automatic logic [FB_ADDR_W-1:0] idx_to_addr(
    input buf_idx_t             idx,
    input logic [FB_ADDR_W-1:0] base_addr,
    input logic [FB_ADDR_W-1:0] frame_bytes
  );
    case (idx)
      2'd0:    idx_to_addr = base_addr;
      2'd1:    idx_to_addr = base_addr + frame_bytes;
      default: idx_to_addr = base_addr + (frame_bytes << 1);
    endcase
  endfunction

endpackage

// File: rtl/frame_buffer_manager_sat_counter.sv
// Saturating event counter; increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_100Mhz,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/frame_buffer_manager.sv
// Triple-buffer owner tracking for writer/reader; swaps on frame-done and vsync.
// Indices and base addresses update on the event edge itself (no extra latency).
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter int              AXI_ADDR_WIDTH = 32,
  parameter logic [31:0]     BASE_ADDR      = 32'h1000_0000,
  parameter int              FRAME_BYTES    = 153600,
  parameter int              CNT_WIDTH      = 16
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr_frame_done,
  input  logic                      vsync_sync2,
  output logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
  output logic [AXI_ADDR_WIDTH-1:0] rd_base_addr,
  output logic                      rd_valid,
  output logic [1:0]                wr_idx,
  output logic [1:0]                rd_idx,
  output logic [1:0]                ready_idx,
  output logic                      ready_pending,
  output logic [CNT_WIDTH-1:0]      frames_dropped,
  output logic [CNT_WIDTH-1:0]      frames_repeated,
  output logic [1:0]                state
);

  localparam logic [FB_ADDR_W-1:0] FRAME_BYTES_W = FB_ADDR_W'(FRAME_BYTES);

  fb_state_t state_q, state_d;
  buf_idx_t  wr_idx_q, wr_idx_d;
  buf_idx_t  rd_idx_q, rd_idx_d;
  buf_idx_t  ready_idx_q, ready_idx_d;
  logic      pend_q, pend_d;
  logic      valid_q, valid_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic      drop_inc;
  logic      rep_inc;

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_idx_q    <= 2'd0;
      ready_idx_q <= 2'd1;
      rd_idx_q    <= 2'd2;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      wr_addr_q   <= AXI_ADDR_WIDTH'(idx_to_addr(2'd0, BASE_ADDR, FRAME_BYTES_W));
      rd_addr_q   <= AXI_ADDR_WIDTH'(idx_to_addr(2'd2, BASE_ADDR, FRAME_BYTES_W));
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      ready_idx_q <= ready_idx_d;
      rd_idx_q    <= rd_idx_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    ready_idx_d = ready_idx_q;
    rd_idx_d    = rd_idx_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    drop_inc    = 1'b0;
    rep_inc     = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_FIRST;
        WAIT_FIRST, RUN: begin
          // Write swap first, so a same-cycle vsync picks up the frame just finished.
          if (wr_frame_done) begin
            wr_idx_d    = ready_idx_q;
            ready_idx_d = wr_idx_q;
            drop_inc    = pend_q;
            pend_d      = 1'b1;
          end
          if (vsync_sync2) begin
            if (pend_d) begin
              rd_idx_d    = ready_idx_d;
              ready_idx_d = rd_idx_q;
              pend_d      = 1'b0;
              if (state_q == WAIT_FIRST) begin
                valid_d = 1'b1;
                state_d = RUN;
              end
            end else if (state_q == RUN) begin
              rep_inc = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    wr_addr_d = AXI_ADDR_WIDTH'(idx_to_addr(wr_idx_d, BASE_ADDR, FRAME_BYTES_W));
    rd_addr_d = AXI_ADDR_WIDTH'(idx_to_addr(rd_idx_d, BASE_ADDR, FRAME_BYTES_W));
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .inc        (drop_inc),
    .count      (frames_dropped)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rep_cnt (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .inc        (rep_inc),
    .count      (frames_repeated)
  );

  assign wr_base_addr  = wr_addr_q;
  assign rd_base_addr  = rd_addr_q;
  assign rd_valid      = valid_q;
  assign wr_idx        = wr_idx_q;
  assign rd_idx        = rd_idx_q;
  assign ready_idx     = ready_idx_q;
  assign ready_pending = pend_q;
  assign state         = state_q;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Scoreboarded random + directed bench for frame_buffer_manager.
module tb_frame_buffer_manager;

  localparam longint BASE  = 64'h1000_0000;
  localparam longint FBYTE = 153600;
  localparam int     SW    = 3;   // narrow counter instance to reach saturation quickly

  logic clk_100Mhz = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, wr_frame_done = 1'b0, vsync_sync2 = 1'b0;

  logic [31:0] wr_base_addr, rd_base_addr;
  logic        rd_valid, ready_pending;
  logic [1:0]  wr_idx, rd_idx, ready_idx, state;
  logic [15:0] frames_dropped, frames_repeated;

  logic [31:0] s_wr_base_addr, s_rd_base_addr;
  logic        s_rd_valid, s_ready_pending;
  logic [1:0]  s_wr_idx, s_rd_idx, s_ready_idx, s_state;
  logic [SW-1:0] s_frames_dropped, s_frames_repeated;

  always #5 clk_100Mhz = ~clk_100Mhz;

  frame_buffer_manager dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .enable(enable),
    .wr_frame_done(wr_frame_done), .vsync_sync2(vsync_sync2),
    .wr_base_addr(wr_base_addr), .rd_base_addr(rd_base_addr), .rd_valid(rd_valid),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .ready_idx(ready_idx),
    .ready_pending(ready_pending), .frames_dropped(frames_dropped),
    .frames_repeated(frames_repeated), .state(state)
  );

  frame_buffer_manager #(.CNT_WIDTH(SW)) dut_s (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .enable(enable),
    .wr_frame_done(wr_frame_done), .vsync_sync2(vsync_sync2),
    .wr_base_addr(s_wr_base_addr), .rd_base_addr(s_rd_base_addr), .rd_valid(s_rd_valid),
    .wr_idx(s_wr_idx), .rd_idx(s_rd_idx), .ready_idx(s_ready_idx),
    .ready_pending(s_ready_pending), .frames_dropped(s_frames_dropped),
    .frames_repeated(s_frames_repeated), .state(s_state)
  );

  typedef struct {
    int     w, p, r, st;
    bit     pend, valid;
    longint wa, ra;
    longint drop, rep, drop_s, rep_s;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: buffer owners by name, true event counts, clamped on compare.
  int     m_w, m_p, m_r, m_st;
  bit     m_pend, m_valid;
  longint m_drop, m_rep;

  function automatic longint clampv(longint v, int width);
    longint mx;
    mx = (64'd1 << width) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_apply(input bit rn, input bit en, input bit wr, input bit vs);
    int t;
    if (!rn) begin
      m_w = 0; m_p = 1; m_r = 2; m_pend = 0; m_valid = 0; m_st = 0;
      m_drop = 0; m_rep = 0;
    end else if (!en) begin
      m_st = 0; m_valid = 0; m_pend = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else begin
      if (wr) begin
        t = m_w; m_w = m_p; m_p = t;
        if (m_pend) m_drop++;
        m_pend = 1;
      end
      if (vs) begin
        if (m_pend) begin
          t = m_r; m_r = m_p; m_p = t;
          m_pend = 0;
          if (m_st == 1) begin m_valid = 1; m_st = 2; end
        end else if (m_st == 2) begin
          m_rep++;
        end
      end
    end
  endtask

  task automatic step(input bit rn, input bit en, input bit wr, input bit vs);
    exp_t e;
    @(negedge clk_100Mhz);
    rst_n = rn; enable = en; wr_frame_done = wr; vsync_sync2 = vs;
    model_apply(rn, en, wr, vs);
    e.w = m_w; e.p = m_p; e.r = m_r; e.st = m_st;
    e.pend = m_pend; e.valid = m_valid;
    e.wa = BASE + m_w * FBYTE;
    e.ra = BASE + m_r * FBYTE;
    e.drop = clampv(m_drop, 16); e.rep = clampv(m_rep, 16);
    e.drop_s = clampv(m_drop, SW); e.rep_s = clampv(m_rep, SW);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1, en, 0, 0);
  endtask

  // Monitor: one expected snapshot per clock edge after the stimulus that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_100Mhz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (wr_idx != e.w[1:0] || ready_idx != e.p[1:0] || rd_idx != e.r[1:0] ||
            state != e.st[1:0] || ready_pending != e.pend || rd_valid != e.valid ||
            wr_base_addr != e.wa[31:0] || rd_base_addr != e.ra[31:0] ||
            frames_dropped != e.drop[15:0] || frames_repeated != e.rep[15:0]) begin
          fails++;
          $display("FAIL snapshot t=%0t: got w/p/r=%0d/%0d/%0d st=%0d pend=%0b vld=%0b wa=%h ra=%h drop=%0d rep=%0d, want w/p/r=%0d/%0d/%0d st=%0d pend=%0b vld=%0b wa=%h ra=%h drop=%0d rep=%0d",
                   $time, wr_idx, ready_idx, rd_idx, state, ready_pending, rd_valid,
                   wr_base_addr, rd_base_addr, frames_dropped, frames_repeated,
                   e.w, e.p, e.r, e.st, e.pend, e.valid, e.wa[31:0], e.ra[31:0], e.drop, e.rep);
        end
        tests++;
        if (s_frames_dropped != e.drop_s[SW-1:0] || s_frames_repeated != e.rep_s[SW-1:0]) begin
          fails++;
          $display("FAIL sat_counters t=%0t: got drop=%0d rep=%0d, want drop=%0d rep=%0d",
                   $time, s_frames_dropped, s_frames_repeated, e.drop_s, e.rep_s);
        end
        tests++;
        if (wr_idx == 2'd3 || rd_idx == 2'd3 || ready_idx == 2'd3 ||
            wr_idx == rd_idx || wr_idx == ready_idx || rd_idx == ready_idx) begin
          fails++;
          $display("FAIL permutation t=%0t: got w/p/r=%0d/%0d/%0d, want a permutation of 0,1,2",
                   $time, wr_idx, ready_idx, rd_idx);
        end
      end
    end
  end

  initial begin
    int budget;
    bit rn, en;
    model_apply(0, 0, 0, 0);

    // Reset, then enable with no writes: vsyncs in WAIT_FIRST are not repeats.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    idle(3, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1);

    // First frame, then vsync 10 cycles later.
    step(1, 1, 1, 0);
    idle(10, 1);
    step(1, 1, 0, 1);

    // Three frames without vsync: two drops.
    for (int i = 0; i < 3; i++) begin step(1, 1, 1, 0); idle(1, 1); end
    step(1, 1, 0, 1);

    // Four vsyncs with no writes in RUN: four repeats.
    for (int i = 0; i < 4; i++) begin step(1, 1, 0, 1); idle(2, 1); end

    // Setup pending=1, then write and vsync in the same cycle.
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    idle(2, 1);

    // Freeze, then reset.
    step(1, 1, 1, 0);
    idle(3, 0);
    step(1, 0, 1, 1);
    step(0, 0, 0, 0);
    idle(2, 1);

    // Randomised traffic with occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 399) != 0);
      en = ($urandom_range(0, 49) != 0);
      step(rn, en, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    // Long repeat / drop streaks to push the narrow counters into saturation.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0);
    idle(2, 1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(posedge clk_100Mhz);
      budget++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d snapshots left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_buffer_manager.md
Name: frame_buffer_manager

Overview:
- Triple-buffer ownership controller for the DDR frame store.
- Shared by the camera-side AXI writer and the HDMI-side AXI reader.
- Hands each side a private frame base address and swaps ownership on frame-complete (writer) and vsync (reader) events.
- Tearing-free output: the writer never writes the buffer being displayed, and the reader always shows the newest complete frame.

Parameters:
- AXI_ADDR_WIDTH, 32, width of all address outputs.
- BASE_ADDR, 32'h1000_0000, DDR byte address of buffer 0.
- FRAME_BYTES, 153600, byte stride between buffers (320x240x2 B).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk_100Mhz  in  1  AXI-domain clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  level; 0 freezes buffer ownership.
- wr_frame_done  in  1  one-cycle pulse from the writer after the last burst of a frame is accepted (BRESP received).
- vsync_sync2  in  1  one-cycle pulse, already synchronised into clk_100Mhz, at the start of the display frame.
- wr_base_addr  out  AXI_ADDR_WIDTH  frame base address for the writer.
- rd_base_addr  out  AXI_ADDR_WIDTH  frame base address for the reader (FRAME_BASE_ADDR).
- rd_valid  out  1  reader buffer holds a complete frame; 0 means the display outputs black.
- wr_idx, rd_idx, ready_idx  out  2 each  current buffer owners (debug).
- ready_pending  out  1  ready_idx holds an unread complete frame.
- frames_dropped  out  CNT_WIDTH  completed frames overwritten before display, saturating.
- frames_repeated  out  CNT_WIDTH  vsyncs that reused the previous frame, saturating.
- state  out  2  FSM state (debug).

Behaviour:
- Reset (rst_n=0 at an edge):
  - wr_idx=0, ready_idx=1, rd_idx=2, ready_pending=0, rd_valid=0.
  - Counters=0, state=IDLE.
  - Addresses match the indices: wr=BASE, rd=BASE+2*FRAME_BYTES.
- Invariant: {wr_idx, ready_idx, rd_idx} is always a permutation of {0,1,2}. Index value 3 never occurs.
- Address rule: addr = BASE_ADDR + idx*FRAME_BYTES, computed from a 3-entry constant mux and registered on the same edge as the index change.
- Latency: an event at edge k makes the new indices and addresses visible after edge k, i.e. 0 extra cycles.
- FSM states: IDLE=0, WAIT_FIRST=1, RUN=2.
  - IDLE: events ignored; indices held. Go to WAIT_FIRST when enable=1.
  - WAIT_FIRST: write events are processed. rd_valid=0. On a vsync that finds ready_pending=1: perform the read swap, set rd_valid=1, go to RUN. vsync with ready_pending=0 does not count as repeated.
  - RUN: both events are processed.
  - enable=0 in any state: next state IDLE, rd_valid<=0, ready_pending<=0. Indices and counters are held.
- Write event (wr_frame_done=1, state != IDLE):
  - swap wr_idx and ready_idx.
  - if ready_pending was already 1, frames_dropped++.
  - ready_pending<=1.
- Read event (vsync_sync2=1, state != IDLE):
  - if ready_pending=1: swap rd_idx and ready_idx, ready_pending<=0.
  - else, in RUN only: frames_repeated++; indices unchanged.
- Simultaneous write and read in one cycle: apply the write then the read, so the display gets the frame just finished.
  - Starting from W,P,R: new wr=P, rd=W, ready=R, ready_pending=0.
  - frames_dropped++ only if the old ready_pending=1.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation overrides everything in the same cycle. No partial swap is observable.

Decomposition:
- Package fb_pkg holds:
  - state encoding IDLE/WAIT_FIRST/RUN;
  - buf_idx_t (2-bit) and NUM_BUF=3;
  - function idx_to_addr(idx, BASE_ADDR, FRAME_BYTES).
- One sub-module, sat_counter (parameter CNT_WIDTH; ports clk_100Mhz, rst_n, inc, count), instantiated twice for the statistics counters.

Test Plan:
- Reset then enable=1 with no events -> wr=0x1000_0000, rd=0x1004_B000, rd_valid=0, state=WAIT_FIRST; 5 vsyncs leave frames_repeated=0.
- One wr_frame_done, then vsync 10 cycles later -> after the pulse: wr_idx=1, ready_idx=0, pending=1. After vsync: rd_idx=0, rd_base=0x1000_0000, rd_valid=1, state=RUN.
- Three wr_frame_done pulses with no vsync -> frames_dropped=2, pending=1, indices remain a permutation, wr_idx never equals rd_idx.
- Four vsyncs with no writes in RUN -> frames_repeated=4, rd_base unchanged.
- wr_frame_done and vsync in the same cycle from W=1,P=0,R=2 with pending=1 -> wr=0, rd=1, ready=2, pending=0, frames_dropped+1.
- enable=0 mid-RUN, then rst_n=0 for 1 cycle -> IDLE with indices frozen and rd_valid=0; after reset, all values are back at their reset state. Counters forced to 0xFFFE then 3 events -> value holds at 0xFFFF.
